// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// Round-robin, packet-granular sharing of one UART tx byte stream among several sources.
// Zero-latency pass-through while locked, one IDLE bubble between packets; tx ready reaches only the owner.
module uart_tx_arbiter #(
   parameter int NumRequesters = 2,
   parameter int DataSize      = 8,
   parameter int TimeoutCycles = 65535
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic [NumRequesters*DataSize-1:0] i_req_data,
   input  logic [NumRequesters-1:0]          i_req_valid,
   input  logic [NumRequesters-1:0]          i_req_last,
   output logic [NumRequesters-1:0]          o_req_ready,
   output logic [DataSize-1:0]               o_tx_data,
   output logic                              o_tx_data_valid,
   input  logic                              i_tx_data_ready,
   output logic [NumRequesters-1:0]          o_grant,
   output logic                              o_busy,
   output logic                              o_timeout
);

   localparam int IdxW = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;
   localparam int WdW  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
   localparam logic [WdW-1:0]  WdTerm  = (TimeoutCycles > 0) ? WdW'(TimeoutCycles - 1) : '0;
   localparam logic [IdxW-1:0] PtrInit = IdxW'(NumRequesters - 1);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [IdxW-1:0] ptr_q, ptr_d;
   logic [IdxW-1:0] gnt_q, gnt_d;
   logic [WdW-1:0]  wd_q, wd_d;
   logic [IdxW-1:0] win_idx;
   logic [IdxW-1:0] cand;
   logic            win_found;
   logic            busy;
   logic            xfer;
   logic            xfer_last;
   logic            wd_terminal;

   assign busy        = (state_q == ST_LOCKED);
   assign xfer        = busy && i_req_valid[gnt_q] && i_tx_data_ready;
   assign xfer_last   = xfer && i_req_last[gnt_q];
   assign wd_terminal = (TimeoutCycles > 0) && busy && !xfer && (wd_q == WdTerm);
   assign o_busy      = busy;

   // Search starts just after the last owner, so that owner has lowest priority next round.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int off = 1; off <= NumRequesters; off++) begin
         cand = IdxW'((int'(ptr_q) + off) % NumRequesters);
         if (!win_found && i_req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gnt_d     = gnt_q;
      wd_d      = wd_q;
      o_timeout = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               state_d = ST_LOCKED;
               gnt_d   = win_idx;
               wd_d    = '0;
            end
         end
         ST_LOCKED: begin
            // A last byte on the watchdog's terminal cycle is a normal packet end.
            if (xfer_last) begin
               state_d = ST_IDLE;
               ptr_d   = gnt_q;
               wd_d    = '0;
            end else if (wd_terminal) begin
               o_timeout = 1'b1;
               state_d   = ST_IDLE;
               ptr_d     = gnt_q;
               wd_d      = '0;
            end else if (xfer) begin
               wd_d = '0;
            end else if (TimeoutCycles > 0) begin
               wd_d = wd_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      o_grant         = '0;
      o_req_ready     = '0;
      o_tx_data       = '0;
      o_tx_data_valid = 1'b0;
      if (busy) begin
         o_grant[gnt_q]     = 1'b1;
         o_req_ready[gnt_q] = i_tx_data_ready;
         o_tx_data          = i_req_data[gnt_q*DataSize +: DataSize];
         o_tx_data_valid    = i_req_valid[gnt_q];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= PtrInit;
         gnt_q   <= '0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         wd_q    <= wd_d;
      end
   end

endmodule
